// File: rtl/piece_move_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : piece_move_ctrl_if
// Brief    : Move request, spawn/lock and collision-check handshake bundle
//            between the game logic and the piece move controller.
// Revision : 1.0
// ============================================================================
interface piece_move_ctrl_if;
    logic       move_left;
    logic       move_right;
    logic       spawn;
    logic       lock;
    logic       chk_req;
    logic [3:0] chk_x;
    logic       chk_ack;
    logic       chk_ok;
    logic [3:0] piece_x;
    logic       move_done;
    logic       chk_err;

    modport master (
        output move_left, move_right, spawn, lock, chk_ack, chk_ok,
        input  chk_req, chk_x, piece_x, move_done, chk_err
    );

    modport slave (
        input  move_left, move_right, spawn, lock, chk_ack, chk_ok,
        output chk_req, chk_x, piece_x, move_done, chk_err
    );
endinterface
`default_nettype wire

// File: rtl/piece_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : piece_move_ctrl
// Brief    : Horizontal piece movement with collision-check handshake,
//            1-deep pending move slot, check timeout and spawn/lock control.
// Revision : 1.0
// ============================================================================
module piece_move_ctrl #(
    parameter int BOARD_W = 10,
    parameter int SPAWN_X = 4,
    parameter int TIMEOUT = 15
) (
    input  wire logic          clk,
    input  wire logic          reset,
    piece_move_ctrl_if.slave   bus
);

    localparam logic [3:0] c_spawn_x  = 4'(SPAWN_X);
    localparam logic [3:0] c_x_max    = 4'(BOARD_W - 1);
    localparam logic [3:0] c_cnt_last = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_piece_x;
    logic [3:0] w_piece_x_nxt;
    logic [3:0] r_chk_x;
    logic [3:0] w_chk_x_nxt;
    logic       r_pend_vld;
    logic       w_pend_vld_nxt;
    logic       r_pend_left;
    logic       w_pend_left_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_chk_err;
    logic       w_chk_err_nxt;
    logic       w_commit;
    logic       w_req_vld;
    logic       w_req_left;
    logic       w_in_vld;
    logic       w_in_left;

    // Simultaneous left+right cancels out.
    assign w_in_vld  = bus.move_left ^ bus.move_right;
    assign w_in_left = bus.move_left;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_piece_x   <= c_spawn_x;
            r_chk_x     <= c_spawn_x;
            r_pend_vld  <= 1'b0;
            r_pend_left <= 1'b0;
            r_cnt       <= '0;
            r_chk_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_piece_x   <= w_piece_x_nxt;
            r_chk_x     <= w_chk_x_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_left <= w_pend_left_nxt;
            r_cnt       <= w_cnt_nxt;
            r_chk_err   <= w_chk_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_piece_x_nxt   = r_piece_x;
        w_chk_x_nxt     = r_chk_x;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_left_nxt = r_pend_left;
        w_cnt_nxt       = r_cnt;
        w_chk_err_nxt   = 1'b0;
        w_commit        = 1'b0;
        w_req_vld       = 1'b0;
        w_req_left      = 1'b0;

        if (bus.spawn) begin
            w_state_nxt    = IDLE;
            w_piece_x_nxt  = c_spawn_x;
            w_chk_x_nxt    = c_spawn_x;
            w_pend_vld_nxt = 1'b0;
            w_cnt_nxt      = '0;
        end else if (bus.lock && (r_state != LOCKED)) begin
            w_state_nxt    = LOCKED;
            w_pend_vld_nxt = 1'b0;
            w_cnt_nxt      = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    // A stored move goes first; a fresh pulse this cycle takes its place in the slot.
                    if (r_pend_vld) begin
                        w_req_vld       = 1'b1;
                        w_req_left      = r_pend_left;
                        w_pend_vld_nxt  = w_in_vld;
                        w_pend_left_nxt = w_in_left;
                    end else begin
                        w_req_vld  = w_in_vld;
                        w_req_left = w_in_left;
                    end
                    if (w_req_vld) begin
                        if (w_req_left && (r_piece_x != 4'd0)) begin
                            w_chk_x_nxt = r_piece_x - 4'd1;
                            w_state_nxt = CHECK;
                        end else if (!w_req_left && (r_piece_x < c_x_max)) begin
                            w_chk_x_nxt = r_piece_x + 4'd1;
                            w_state_nxt = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_in_vld && !r_pend_vld) begin
                        w_pend_vld_nxt  = 1'b1;
                        w_pend_left_nxt = w_in_left;
                    end
                    if (bus.chk_ack) begin
                        w_state_nxt = bus.chk_ok ? COMMIT : IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= c_cnt_last) begin
                        w_state_nxt    = IDLE;
                        w_chk_err_nxt  = 1'b1;
                        w_pend_vld_nxt = 1'b0;
                        w_cnt_nxt      = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                COMMIT: begin
                    if (w_in_vld && !r_pend_vld) begin
                        w_pend_vld_nxt  = 1'b1;
                        w_pend_left_nxt = w_in_left;
                    end
                    w_commit      = 1'b1;
                    w_piece_x_nxt = r_chk_x;
                    w_state_nxt   = IDLE;
                end
                LOCKED: begin
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    // The new column is visible during COMMIT itself; a same-cycle lock or spawn cancels it.
    assign bus.piece_x   = w_commit ? r_chk_x : r_piece_x;
    assign bus.move_done = w_commit;
    assign bus.chk_req   = (r_state == CHECK);
    assign bus.chk_x     = r_chk_x;
    assign bus.chk_err   = r_chk_err;

endmodule
`default_nettype wire

// File: tb/tb_piece_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_piece_move_ctrl
// Brief    : Scoreboard bench for piece_move_ctrl: expected columns are queued
//            on each press and compared whenever move_done pulses.
// Revision : 1.0
// ============================================================================
module tb_piece_move_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   exp_q[$];

    piece_move_ctrl_if bus ();

    piece_move_ctrl #(
        .BOARD_W (10),
        .SPAWN_X (4),
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic l, input logic r);
        bus.move_left  = l;
        bus.move_right = r;
        step();
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
    endtask

    // Waits for chk_req, answers with one ack cycle, returns at posedge+1.
    task automatic ack_when_req(input logic ok);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.chk_req) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("req_seen", 32'(seen), 32'd1);
        bus.chk_ack = seen;
        bus.chk_ok  = ok;
        step();
        bus.chk_ack = 1'b0;
        bus.chk_ok  = 1'b0;
    endtask

    task automatic move(input logic right, input int exp_x);
        exp_q.push_back(exp_x);
        press(!right, right);
        ack_when_req(1'b1);
        step();
    endtask

    task automatic expect_no_req(input string tag, input int cycles);
        int n_req;
        n_req = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.chk_req) n_req++;
        end
        check_val(tag, 32'(n_req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every move_done must match the oldest queued column.
    always @(negedge clk) begin
        if (bus.move_done) begin
            if (exp_q.size() > 0) check_val("move_piece_x", 32'(bus.piece_x), 32'(exp_q.pop_front()));
            else                  check_val("unexpected_move_done", 32'(bus.move_done), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;
        bit err_seen;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        bus.move_left = 1'b0; bus.move_right = 1'b0;
        bus.spawn = 1'b0; bus.lock = 1'b0;
        bus.chk_ack = 1'b0; bus.chk_ok = 1'b0;
        repeat (3) step();

        @(negedge clk);
        check_val("rst_piece_x", 32'(bus.piece_x), 32'd4);
        check_val("rst_chk_x", 32'(bus.chk_x), 32'd4);
        check_val("rst_chk_req", 32'(bus.chk_req), 32'd0);
        check_val("rst_move_done", 32'(bus.move_done), 32'd0);
        check_val("rst_chk_err", 32'(bus.chk_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        @(negedge clk);
        check_val("post_rst_quiet", 32'({bus.chk_req, bus.move_done, bus.chk_err}), 32'd0);
        @(posedge clk); #1;

        // Basic right move with fastest ack
        exp_q.push_back(5);
        press(1'b0, 1'b1);
        @(negedge clk);
        check_val("first_chk_req", 32'(bus.chk_req), 32'd1);
        check_val("first_chk_x", 32'(bus.chk_x), 32'd5);
        ack_when_req(1'b1);
        step();
        check_val("piece_x_5", 32'(bus.piece_x), 32'd5);

        // Right edge, then left edge
        for (int x = 6; x <= 9; x++) move(1'b1, x);
        press(1'b0, 1'b1);
        expect_no_req("no_req_right_edge", 3);
        check_val("stay_at_9", 32'(bus.piece_x), 32'd9);
        for (int x = 8; x >= 0; x--) move(1'b0, x);
        press(1'b1, 1'b0);
        expect_no_req("no_req_left_edge", 3);
        check_val("stay_at_0", 32'(bus.piece_x), 32'd0);
        bus.spawn = 1'b1; step(); bus.spawn = 1'b0;
        check_val("spawn_piece_x", 32'(bus.piece_x), 32'd4);

        // Rejected check leaves piece_x alone
        press(1'b0, 1'b1);
        ack_when_req(1'b0);
        expect_no_req("reject_no_retry", 3);
        check_val("reject_piece_x", 32'(bus.piece_x), 32'd4);

        // Pending slot: right, left stored, second left dropped
        exp_q.push_back(5);
        press(1'b0, 1'b1);
        exp_q.push_back(4);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        ack_when_req(1'b1);
        ack_when_req(1'b1);
        expect_no_req("third_pulse_dropped", 4);
        check_val("pending_final_x", 32'(bus.piece_x), 32'd4);

        // Timeout after 15 check cycles, late ack ignored
        press(1'b0, 1'b1);
        n_req = 0;
        err_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.chk_err) begin
                err_seen = 1'b1;
                break;
            end
            if (bus.chk_req) n_req++;
        end
        check_val("timeout_err_seen", 32'(err_seen), 32'd1);
        check_val("timeout_cycles", 32'(n_req), 32'd15);
        check_val("timeout_req_low", 32'(bus.chk_req), 32'd0);
        check_val("timeout_piece_x", 32'(bus.piece_x), 32'd4);
        bus.chk_ack = 1'b1; bus.chk_ok = 1'b1;
        step();
        bus.chk_ack = 1'b0; bus.chk_ok = 1'b0;
        @(negedge clk);
        check_val("late_ack_no_done", 32'(bus.move_done), 32'd0);
        check_val("err_one_cycle", 32'(bus.chk_err), 32'd0);
        check_val("late_ack_piece_x", 32'(bus.piece_x), 32'd4);
        @(posedge clk); #1;

        // Lock during CHECK wins over a same-cycle ack
        press(1'b0, 1'b1);
        bus.lock = 1'b1; bus.chk_ack = 1'b1; bus.chk_ok = 1'b1;
        step();
        bus.lock = 1'b0; bus.chk_ack = 1'b0; bus.chk_ok = 1'b0;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        bus.chk_ack = 1'b1; bus.chk_ok = 1'b1; step(); bus.chk_ack = 1'b0; bus.chk_ok = 1'b0;
        expect_no_req("locked_no_req", 3);
        check_val("locked_piece_x", 32'(bus.piece_x), 32'd4);
        bus.spawn = 1'b1; bus.lock = 1'b1; step(); bus.spawn = 1'b0; bus.lock = 1'b0;
        check_val("spawn_over_lock_x", 32'(bus.piece_x), 32'd4);
        move(1'b1, 5);
        move(1'b0, 4);

        // Lock in the commit cycle discards the commit
        press(1'b0, 1'b1);
        ack_when_req(1'b1);
        bus.lock = 1'b1;
        @(negedge clk);
        check_val("lock_commit_no_done", 32'(bus.move_done), 32'd0);
        check_val("lock_commit_piece_x", 32'(bus.piece_x), 32'd4);
        @(posedge clk); #1;
        bus.lock = 1'b0;
        bus.spawn = 1'b1; step(); bus.spawn = 1'b0;

        // Simultaneous press ignored; reset mid-CHECK
        move(1'b1, 5);
        press(1'b1, 1'b1);
        expect_no_req("both_dirs_no_req", 3);
        press(1'b0, 1'b1);
        @(negedge clk);
        check_val("pre_reset_chk_x", 32'(bus.chk_x), 32'd6);
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        bus.chk_ack = 1'b1; bus.chk_ok = 1'b1;
        @(negedge clk);
        check_val("midrst_piece_x", 32'(bus.piece_x), 32'd4);
        check_val("midrst_chk_x", 32'(bus.chk_x), 32'd4);
        check_val("midrst_outs", 32'({bus.chk_req, bus.move_done, bus.chk_err}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        bus.chk_ack = 1'b0; bus.chk_ok = 1'b0;
        @(negedge clk);
        check_val("after_rst_quiet", 32'({bus.chk_req, bus.move_done, bus.chk_err}), 32'd0);
        @(posedge clk); #1;
        move(1'b0, 3);

        repeat (2) step();
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
